// File: rtl/keypad_matrix_scanner_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
//  Shared types, constants and small helpers for the 4x4 keypad scanner.
//  - kp_state_e    : debounce FSM states
//  - COL_DRIVE_x   : active-low column drive patterns, one column low
//  - is_onehot     : true when exactly one key is seen in a snapshot
//  - onehot_idx    : bit position of the single set bit
//  - bit_to_code   : snapshot bit (col*4+row) -> key code (row*4+col)
// ----------------------------------------------------------------------------
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } kp_state_e;

    localparam logic [NUM_COLS-1:0] COL_DRIVE_0 = 4'b1110;
    localparam logic [NUM_COLS-1:0] COL_DRIVE_1 = 4'b1101;
    localparam logic [NUM_COLS-1:0] COL_DRIVE_2 = 4'b1011;
    localparam logic [NUM_COLS-1:0] COL_DRIVE_3 = 4'b0111;

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    function automatic logic [3:0] onehot_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Snapshot bits are laid out column-major; key codes are row-major.
    function automatic logic [KEY_W-1:0] bit_to_code(input logic [3:0] b);
        return {b[1:0], b[3:2]};
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_scan_timer.sv
// ----------------------------------------------------------------------------
// kp_scan_timer
//  Column scan sequencer. Each column is driven low for SCAN_DIV clocks; the
//  rows are sampled on the last dwell cycle of each column.
//  Ports:
//   clk_arg, rstn   clock, async active-low reset
//   col             index of the column currently driven (0..3)
//   col_n           active-low column drive, exactly one bit low
//   sample          strobe: capture rows for column 'col' this cycle
//   scan_done       strobe: the column-3 sample completing a full scan
// ----------------------------------------------------------------------------
module kp_scan_timer
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 25_000
) (
    input  logic                clk_arg,
    input  logic                rstn,
    output logic [1:0]          col,
    output logic [NUM_COLS-1:0] col_n,
    output logic                sample,
    output logic                scan_done
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;

    always_comb begin
        sample    = (dwell_q == DW'(SCAN_DIV - 1));
        scan_done = sample && (col_q == 2'd3);
        dwell_d   = dwell_q + DW'(1);
        col_d     = col_q;
        if (sample) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;   // wraps 3 -> 0
        end
    end

    always_comb begin
        col = col_q;
        unique case (col_q)
            2'd0:    col_n = COL_DRIVE_0;
            2'd1:    col_n = COL_DRIVE_1;
            2'd2:    col_n = COL_DRIVE_2;
            default: col_n = COL_DRIVE_3;
        endcase
    end

    always_ff @(posedge clk_arg or negedge rstn) begin
        if (!rstn) begin
            dwell_q <= '0;
            col_q   <= 2'd0;
        end else begin
            dwell_q <= dwell_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// ----------------------------------------------------------------------------
// keypad_matrix_scanner
//  Scans a 4x4 active-low keypad, debounces over whole scans and reports
//  single key presses through a one-entry valid/ack buffer.
//  Ports:
//   clk_arg, rstn  clock, async active-low reset
//   row_n[3:0]     keypad rows, active-low, asynchronous
//   col_n[3:0]     column drive, active-low, one bit low
//   key_code[3:0]  accepted key, row*4+col
//   key_valid      key_code pending, held until key_ack
//   key_ack        consumer takes the pending key
//   key_held       debounced key currently down
//   overflow       sticky: a press was dropped with the buffer full
//  Handshake: key_valid is a level; a cycle with key_valid=1 and key_ack=1
//  transfers key_code. A new key arriving in that same cycle replaces it and
//  keeps key_valid high; a new key arriving while key_valid=1 and key_ack=0
//  is dropped and sets overflow.
// ----------------------------------------------------------------------------
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 25_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                clk_arg,
    input  logic                rstn,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic [KEY_W-1:0]    key_code,
    output logic                key_valid,
    input  logic                key_ack,
    output logic                key_held,
    output logic                overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [1:0] col;
    logic       sample;
    logic       scan_done;

    kp_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
        .clk_arg   (clk_arg),
        .rstn      (rstn),
        .col       (col),
        .col_n     (col_n),
        .sample    (sample),
        .scan_done (scan_done)
    );

    // Synchronizer resets to "no key" so the first samples read as released.
    logic [NUM_ROWS-1:0] rsync1_q, rsync2_q;
    logic [15:0]         snap_q, snap_d;
    kp_state_e           state_q, state_d;
    logic [3:0]          cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0]    key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                overflow_q, overflow_d;
    logic                evt;
    logic [KEY_W-1:0]    evt_code;

    // snap_d already holds the column-3 sample on scan_done, so the FSM
    // judges the complete scan in the same cycle it finishes.
    always_comb begin
        snap_d = snap_q;
        if (sample) snap_d[{col, 2'b00} +: 4] = ~rsync2_q;
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        evt      = 1'b0;
        cnt_inc  = cnt_q + CNT_W'(1);
        if (scan_done) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_onehot(snap_d)) begin
                        cand_d = onehot_idx(snap_d);
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = S_HELD;
                            evt     = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_PRESS_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                S_PRESS_DB: begin
                    if (snap_d == (16'd1 << cand_q)) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_d = S_HELD;
                            evt     = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_HELD: begin
                    // Extra keys while held (ghosting) are ignored until all clear.
                    if (snap_d == 16'd0) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_REL_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                default: begin  // S_REL_DB
                    if (snap_d == 16'd0) begin
                        if (cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end
                end
            endcase
        end
        evt_code = bit_to_code(cand_d);
    end

    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overflow_d  = overflow_q;
        if (evt) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = evt_code;
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (key_ack) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_arg or negedge rstn) begin
        if (!rstn) begin
            rsync1_q    <= '1;
            rsync2_q    <= '1;
            snap_q      <= '0;
            state_q     <= S_IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rsync1_q    <= row_n;
            rsync2_q    <= rsync1_q;
            snap_q      <= snap_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overflow  = overflow_q;
    // Still "down" while the release is being debounced.
    assign key_held  = (state_q == S_HELD) || (state_q == S_REL_DB);

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//  Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
//  A scan is 16 clocks; after a reset release the k-th rising edge is edge_cnt=k,
//  full scans complete at edges 16, 32, 48, ...
// ----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

    logic       clk_arg;
    logic       rstn;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overflow;

    logic [15:0] pressed;   // indexed by key code row*4+col
    int          edge_cnt;
    int          pass_cnt;
    int          total_cnt;

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk_arg   (clk_arg),
        .rstn      (rstn),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    // clock / reset
    initial begin
        clk_arg = 1'b0;
        forever #5 clk_arg = ~clk_arg;
    end

    always @(posedge clk_arg or negedge rstn) begin
        if (!rstn) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // keypad model
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // driver tasks
    task automatic do_reset();
        @(negedge clk_arg);
        rstn = 1'b0;
        repeat (2) @(negedge clk_arg);
        rstn = 1'b1;
    endtask

    task automatic goto(input int k);
        while (edge_cnt < k) @(negedge clk_arg);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic [3:0] code, input logic v,
                              input logic h, input logic o);
        check({tag, ".key_code"}, 16'(key_code), 16'(code));
        check({tag, ".key_valid"}, 16'(key_valid), 16'(v));
        check({tag, ".key_held"}, 16'(key_held), 16'(h));
        check({tag, ".overflow"}, 16'(overflow), 16'(o));
    endtask

    logic [3:0] exp_col;

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rstn      = 1'b0;
        key_ack   = 1'b0;
        pressed   = 16'd0;

        // 1: idle scanning
        do_reset();
        check_outs("t1_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            goto(k);
            exp_col = 4'b0001 << ((k / 4) % 4);
            exp_col = ~exp_col;
            check($sformatf("t1_col_n_k%0d", k), 16'(col_n), 16'(exp_col));
        end
        check_outs("t1_idle", 4'd0, 1'b0, 1'b0, 1'b0);

        // 2: hold r=2,c=1 (code 9), ack, release
        do_reset();
        pressed[9] = 1'b1;
        goto(47);
        check_outs("t2_before", 4'd0, 1'b0, 1'b0, 1'b0);
        goto(48);
        check_outs("t2_accept", 4'd9, 1'b1, 1'b1, 1'b0);
        goto(50);
        key_ack = 1'b1;
        goto(51);
        key_ack = 1'b0;
        check("t2_ack_clears", 16'(key_valid), 16'd0);
        pressed[9] = 1'b0;
        goto(95);
        check("t2_held_rel_db", 16'(key_held), 16'd1);
        goto(96);
        check("t2_released", 16'(key_held), 16'd0);

        // 3: one-scan bounce
        do_reset();
        pressed[9] = 1'b1;
        goto(16);
        pressed[9] = 1'b0;
        goto(100);
        check_outs("t3_bounce", 4'd0, 1'b0, 1'b0, 1'b0);

        // 4: ghost pair 0+5, then release 5
        do_reset();
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        goto(64);
        check_outs("t4_multi", 4'd0, 1'b0, 1'b0, 1'b0);
        pressed[5] = 1'b0;
        goto(111);
        check("t4_before", 16'(key_valid), 16'd0);
        goto(112);
        check_outs("t4_accept0", 4'd0, 1'b1, 1'b1, 1'b0);

        // 5: overflow, then replace with ack in event cycle
        do_reset();
        pressed = 16'd0;
        pressed[3] = 1'b1;
        goto(48);
        check_outs("t5_code3", 4'd3, 1'b1, 1'b1, 1'b0);
        pressed[3] = 1'b0;
        goto(96);
        check("t5_rel3", 16'(key_held), 16'd0);
        pressed[7] = 1'b1;
        goto(143);
        check("t5_no_ovf_yet", 16'(overflow), 16'd0);
        goto(144);
        check_outs("t5_overflow", 4'd3, 1'b1, 1'b1, 1'b1);
        pressed[7] = 1'b0;
        goto(192);
        pressed[7] = 1'b1;
        goto(239);
        key_ack = 1'b1;
        goto(240);
        key_ack = 1'b0;
        check_outs("t5_ack_replace", 4'd7, 1'b1, 1'b1, 1'b1);

        // 6: reset during press debounce, key still held afterwards
        pressed[7] = 1'b0;
        goto(288);
        pressed[9] = 1'b1;
        goto(310);
        check("t6_col_before", 16'(col_n), 16'h000D);
        rstn = 1'b0;
        #1;
        check("t6_col_reset", 16'(col_n), 16'h000E);
        check_outs("t6_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk_arg);
        rstn = 1'b1;
        goto(47);
        check("t6_fresh_before", 16'(key_valid), 16'd0);
        goto(48);
        check_outs("t6_fresh_accept", 4'd9, 1'b1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
